// File: rtl/press_sequencer.sv
// press_sequencer: classifies a debounced button level into short, double and
// long presses, emitting one-cycle event pulses and owning the toggle state.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   pressed      debounced button level (1 = held), synchronous to clk
//   short_pulse  one-cycle pulse: completed single short press
//   double_pulse one-cycle pulse: completed double press
//   long_pulse   one-cycle pulse: long press detected
//   out          toggle state (short toggles, long clears, double keeps)
//   busy         high whenever the sequencer is not idle
module press_sequencer #(
    parameter int unsigned CW          = 26,
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic out,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Terminal counts: cnt already holds the number of samples taken so far,
    // so the sample that arrives while cnt == N-1 is the N-th one.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          short_n, double_n, long_n, out_n, busy_n;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            out          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            short_pulse  <= short_n;
            double_pulse <= double_n;
            long_pulse   <= long_n;
            out          <= out_n;
            busy         <= busy_n;
        end
    end

    // Next-state, counter and event decode.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        short_n  = 1'b0;
        double_n = 1'b0;
        long_n   = 1'b0;
        out_n    = out;

        case (state)
            IDLE: begin
                if (pressed) begin
                    state_n = PRESS1;
                    cnt_n   = CNT_ONE;
                end
            end

            PRESS1: begin
                if (!pressed) begin
                    // Release sample counts as the first gap sample.
                    state_n = GAP;
                    cnt_n   = CNT_ONE;
                end else if (cnt == LONG_LAST) begin
                    state_n = HOLD;
                    long_n  = 1'b1;
                    out_n   = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            GAP: begin
                if (pressed) begin
                    state_n = PRESS2;
                    cnt_n   = CNT_ONE;
                end else if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    short_n = 1'b1;
                    out_n   = ~out;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            PRESS2: begin
                if (!pressed) begin
                    state_n  = IDLE;
                    double_n = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    // A long second press overrides the pending double.
                    state_n = HOLD;
                    long_n  = 1'b1;
                    out_n   = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            HOLD: begin
                if (!pressed) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // busy is registered alongside the state it describes.
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_press_sequencer.sv
module tb_press_sequencer;

    localparam int unsigned CW   = 4;
    localparam int unsigned LONG = 8;
    localparam int unsigned GAPC = 4;

    logic clk = 1'b0;
    logic reset;
    logic pressed;
    logic short_pulse, double_pulse, long_pulse, out, busy;

    int checks = 0;
    int errors = 0;

    press_sequencer #(.CW(CW), .LONG_CYCLES(LONG), .GAP_CYCLES(GAPC)) dut (
        .clk          (clk),
        .reset        (reset),
        .pressed      (pressed),
        .short_pulse  (short_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .out          (out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Vector record: exp = {short, double, long, out, busy}
    typedef struct packed {
        logic       rst;
        logic       p;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void addn(input int n, input logic r, input logic p, input logic [4:0] e);
        vec_t v;
        v.rst = r;
        v.p   = p;
        v.exp = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {s,d,l,out,busy}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic p, output logic [4:0] got);
        @(negedge clk);
        reset   = r;
        pressed = p;
        @(posedge clk);
        #1;
        got = {short_pulse, double_pulse, long_pulse, out, busy};
    endtask

    // Reference model: works on run lengths of the input level and the
    // number of presses seen in the current pattern.
    logic m_prev;
    int   m_run;
    int   m_presses;
    bit   m_locked;
    logic m_out;

    task automatic model_step(input logic r, input logic p, output logic [4:0] e);
        logic s, d, l;
        s = 1'b0; d = 1'b0; l = 1'b0;
        if (r) begin
            m_prev = 1'b0; m_run = 0; m_presses = 0; m_locked = 1'b0; m_out = 1'b0;
        end else begin
            m_run  = (p == m_prev) ? m_run + 1 : 1;
            m_prev = p;
            if (m_locked) begin
                if (!p) m_locked = 1'b0;
            end else if (p) begin
                if (m_run == 1) m_presses++;
                if (m_run == LONG) begin
                    l = 1'b1; m_out = 1'b0; m_locked = 1'b1; m_presses = 0;
                end
            end else begin
                if (m_presses == 2) begin
                    d = 1'b1; m_presses = 0;
                end else if (m_presses == 1 && m_run == GAPC) begin
                    s = 1'b1; m_out = ~m_out; m_presses = 0;
                end
            end
        end
        e = {s, d, l, m_out, logic'(m_presses != 0 || m_locked)};
    endtask

    initial begin
        logic [4:0] got, exp;
        int         lat;
        logic       lvl;
        int         run_left;
        logic       r;

        reset   = 1'b1;
        pressed = 1'b0;

        // Reset
        addn(2, 1, 0, 5'b00000);
        // Short press: high 3, low 4 -> short, out 0->1
        addn(3, 0, 1, 5'b00001);
        addn(3, 0, 0, 5'b00001);
        addn(1, 0, 0, 5'b10010);
        addn(1, 0, 0, 5'b00010);
        // Double press: high 3, low 2, high 3, low -> double, out stays 1
        addn(3, 0, 1, 5'b00011);
        addn(2, 0, 0, 5'b00011);
        addn(3, 0, 1, 5'b00011);
        addn(1, 0, 0, 5'b01010);
        addn(1, 0, 0, 5'b00010);
        // Long press: high 20 -> one long after 8th sample, out cleared
        addn(7, 0, 1, 5'b00011);
        addn(1, 0, 1, 5'b00101);
        addn(12, 0, 1, 5'b00001);
        addn(3, 0, 0, 5'b00000);
        // Long second press: high 2, low 1, high 10 -> long only
        addn(2, 0, 1, 5'b00001);
        addn(1, 0, 0, 5'b00001);
        addn(7, 0, 1, 5'b00001);
        addn(1, 0, 1, 5'b00101);
        addn(2, 0, 1, 5'b00001);
        addn(1, 0, 0, 5'b00000);
        // Minimum press -> out 0->1
        addn(1, 0, 1, 5'b00001);
        addn(3, 0, 0, 5'b00001);
        addn(1, 0, 0, 5'b10010);
        // Reset mid-pattern: high 2, low 2, reset -> no pulse, out/busy 0
        addn(2, 0, 1, 5'b00011);
        addn(2, 0, 0, 5'b00011);
        addn(1, 1, 0, 5'b00000);
        addn(1, 0, 0, 5'b00000);
        // Pressed held across reset deassertion starts a press immediately
        addn(1, 1, 1, 5'b00000);
        addn(1, 0, 1, 5'b00001);
        addn(3, 0, 0, 5'b00001);
        addn(1, 0, 0, 5'b10010);
        // Second minimum press -> out 1->0
        addn(1, 0, 1, 5'b00011);
        addn(3, 0, 0, 5'b00011);
        addn(1, 0, 0, 5'b10000);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].p, got);
            check($sformatf("vec[%0d]", i), got, tbl[i].exp);
        end

        // Long-press latency: pulse after the LONG-th high sample.
        step(1, 0, got);
        lat = -1;
        for (int c = 1; c <= 50; c++) begin
            step(0, 1, got);
            if (got[2]) begin lat = c; break; end
        end
        checks++;
        if (lat != int'(LONG)) begin
            errors++;
            $display("FAIL long_latency: got %0d expected %0d", lat, LONG);
        end
        step(0, 0, got);
        check("after_hold_release", got, 5'b00000);

        // Short-press latency: exactly GAP cycles from release.
        step(0, 1, got);
        step(0, 1, got);
        lat = -1;
        for (int c = 1; c <= 50; c++) begin
            step(0, 0, got);
            if (got[4]) begin lat = c; break; end
        end
        checks++;
        if (lat != int'(GAPC)) begin
            errors++;
            $display("FAIL short_latency: got %0d expected %0d", lat, GAPC);
        end
        check("short_out", got, 5'b10010);

        // Randomized runs of levels against the reference model.
        step(1, 0, got);
        model_step(1, 0, exp);
        check("rand_reset", got, exp);
        lvl = 1'b0;
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                lvl = ~lvl;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            r = ($urandom_range(0, 99) == 0);
            step(r, lvl, got);
            model_step(r, lvl, exp);
            check($sformatf("rand[%0d]", c), got, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
